// File: rtl/sort_engine_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : sort_engine_if
// Brief    : Valid/ready input and output streams of the sort engine.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface sort_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  // Environment side: produces input words, consumes sorted words
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Sorter side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/sort_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : sort_engine
// Brief    : Streaming frame sorter using odd-even transposition. Loads
//            NUM_DATA words, runs NUM_DATA compare/swap phases, then streams
//            the sorted frame out with a last marker.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module sort_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DATA   = 8,
  parameter bit DESCEND    = 1'b0,
  parameter bit SIGNED     = 1'b0
) (
  input  wire logic     clk,
  input  wire logic     rst,   // asynchronous, active low
  sort_engine_if.slave  bus,
  output logic          busy
);

  localparam int IW = $clog2(NUM_DATA);
  localparam int CW = IW + 1;

  localparam logic [CW-1:0] c_last = CW'(NUM_DATA - 1);
  localparam logic [CW-1:0] c_one  = CW'(1);

  localparam logic [1:0] c_st_load   = 2'd0;
  localparam logic [1:0] c_st_sort   = 2'd1;
  localparam logic [1:0] c_st_unload = 2'd2;

  logic [1:0]            r_state;
  logic [CW-1:0]         r_wr_cnt;
  logic [CW-1:0]         r_ph_cnt;
  logic [CW-1:0]         r_rd_cnt;
  logic [DATA_WIDTH-1:0] r_buf  [NUM_DATA];
  logic [DATA_WIDTH-1:0] w_next [NUM_DATA];
  logic [NUM_DATA-2:0]   w_swap;

  // One comparator per adjacent pair; w_swap[i] means pair (i,i+1) is strictly out of order
  for (genvar gi = 0; gi < NUM_DATA - 1; gi++) begin : g_cmp
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    // Descending order is ascending order with the operands exchanged
    assign w_a = DESCEND ? r_buf[gi+1] : r_buf[gi];
    assign w_b = DESCEND ? r_buf[gi]   : r_buf[gi+1];
    if (SIGNED) begin : g_signed
      assign w_swap[gi] = $signed(w_a) > $signed(w_b);
    end else begin : g_unsigned
      assign w_swap[gi] = w_a > w_b;
    end
  end

  // Next buffer contents for the current phase: even phases pair (0,1),(2,3)..,
  // odd phases pair (1,2),(3,4)..; an unpaired end element keeps its value
  always_comb begin
    for (int i = 0; i < NUM_DATA; i++) begin
      w_next[i] = r_buf[i];
    end
    for (int i = 0; i < NUM_DATA - 1; i++) begin
      if ((i[0] == r_ph_cnt[0]) && w_swap[i]) begin
        w_next[i]   = r_buf[i+1];
        w_next[i+1] = r_buf[i];
      end
    end
  end

  // Frame buffer: captured word by word in LOAD, permuted once per SORT phase
  always_ff @(posedge clk) begin
    if ((r_state == c_st_load) && bus.in_valid) begin
      r_buf[r_wr_cnt[IW-1:0]] <= bus.in_data;
    end else if (r_state == c_st_sort) begin
      r_buf <= w_next;
    end
  end

  // Control FSM and its write / phase / read counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= c_st_load;
      r_wr_cnt <= '0;
      r_ph_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      case (r_state)
        c_st_load: begin
          if (bus.in_valid) begin
            if (r_wr_cnt == c_last) begin
              r_wr_cnt <= '0;
              r_ph_cnt <= '0;
              r_state  <= c_st_sort;
            end else begin
              r_wr_cnt <= r_wr_cnt + c_one;
            end
          end
        end
        c_st_sort: begin
          if (r_ph_cnt == c_last) begin
            r_ph_cnt <= '0;
            r_rd_cnt <= '0;
            r_state  <= c_st_unload;
          end else begin
            r_ph_cnt <= r_ph_cnt + c_one;
          end
        end
        c_st_unload: begin
          if (bus.out_ready) begin
            if (r_rd_cnt == c_last) begin
              r_rd_cnt <= '0;
              r_state  <= c_st_load;
            end else begin
              r_rd_cnt <= r_rd_cnt + c_one;
            end
          end
        end
        default: begin
          r_state <= c_st_load;
        end
      endcase
    end
  end

  // Handshake and status outputs decode registered state only
  assign bus.in_ready  = (r_state == c_st_load);
  assign bus.out_valid = (r_state == c_st_unload);
  assign bus.out_last  = (r_state == c_st_unload) && (r_rd_cnt == c_last);
  assign bus.out_data  = (r_state == c_st_unload) ? r_buf[r_rd_cnt[IW-1:0]] : '0;
  assign busy          = (r_state == c_st_sort) || (r_state == c_st_unload);

endmodule
`default_nettype wire

// File: tb/tb_sort_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_sort_engine
// Brief    : Self-checking bench for sort_engine. Four instances:
//            0: N=8 ascending unsigned, 1: N=8 descending signed,
//            2: N=5 ascending unsigned, 3: N=3 ascending unsigned.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sort_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   t_last   = 0;

  logic [3:0]      iv;
  logic [3:0][7:0] idat;
  logic [3:0]      ordy;
  wire  [3:0]      ir;
  wire  [3:0]      ov;
  wire  [3:0]      ol;
  wire  [3:0]      bsy;
  wire  [3:0][7:0] od;

  logic [7:0] tx [8];
  logic [7:0] ex [8];

  // 100 MHz clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int ND = (g == 2) ? 5 : (g == 3) ? 3 : 8;
    localparam bit DS = (g == 1);
    sort_engine_if #(.DATA_WIDTH(8)) bus ();
    assign bus.in_valid  = iv[g];
    assign bus.in_data   = idat[g];
    assign bus.out_ready = ordy[g];
    assign ir[g]         = bus.in_ready;
    assign ov[g]         = bus.out_valid;
    assign ol[g]         = bus.out_last;
    assign od[g]         = bus.out_data;
    sort_engine #(
      .DATA_WIDTH(8), .NUM_DATA(ND), .DESCEND(DS), .SIGNED(DS)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .busy(bsy[g])
    );
  end

  function automatic int nd(input int k);
    return (k == 2) ? 5 : (k == 3) ? 3 : 8;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference ascending unsigned sort of tx into ex (instance 0 only)
  task automatic ref_sort();
    logic [7:0] v;
    int j;
    for (int i = 0; i < 8; i++) ex[i] = tx[i];
    for (int i = 1; i < 8; i++) begin
      v = ex[i];
      j = i - 1;
      while (j >= 0 && ex[j] > v) begin
        ex[j+1] = ex[j];
        j--;
      end
      ex[j+1] = v;
    end
  endtask

  // Present tx[0..N-1]; optional random valid gaps; optionally leave in_valid
  // high with 0xAA afterwards to probe that the sorter ignores it
  task automatic send_frame(input int k, input bit gaps, input bit hold);
    int i = 0;
    int guard = 0;
    while (i < nd(k) && guard < 500) begin
      @(negedge clk);
      guard++;
      iv[k]   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      idat[k] = tx[i];
      if (iv[k] && ir[k]) begin
        i++;
        t_last = cyc + 1;
      end
    end
    check("send_count", i, nd(k));
    @(negedge clk);
    check("busy_in_sort", bsy[k], 1'b1);
    check("in_ready_in_sort", ir[k], 1'b0);
    iv[k]   = hold;
    idat[k] = 8'hAA;
  endtask

  // Collect N words and compare with ex; optional random back-pressure
  task automatic recv_frame(input int k, input bit bp, input bit lat);
    int idx = 0;
    int guard = 0;
    bit stalled = 1'b0;
    bit first = 1'b1;
    logic [7:0] held = '0;
    logic held_last = 1'b0;
    while (idx < nd(k) && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (ov[k]) begin
        if (first && lat) check("latency", cyc - t_last, nd(k));
        first = 1'b0;
        if (stalled) begin
          check("hold_data", od[k], held);
          check("hold_last", ol[k], held_last);
        end
        check("out_data", od[k], ex[idx]);
        check("out_last", ol[k], (idx == nd(k) - 1));
        check("in_ready_unload", ir[k], 1'b0);
        ordy[k]   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        stalled   = !ordy[k];
        held      = od[k];
        held_last = ol[k];
        if (ordy[k]) idx++;
      end else begin
        check("out_data_idle", od[k], 8'h00);
        ordy[k] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    check("recv_count", idx, nd(k));
    @(negedge clk);
    check("in_ready_rearm", ir[k], 1'b1);
    check("out_valid_after", ov[k], 1'b0);
    check("busy_after", bsy[k], 1'b0);
    iv[k]   = 1'b0;
    ordy[k] = 1'b0;
  endtask

  initial begin
    int guard;
    iv   = '0;
    ordy = '0;
    idat = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_in_ready", ir[k], 1'b1);
      check("rst_out_valid", ov[k], 1'b0);
      check("rst_out_data", od[k], 8'h00);
      check("rst_out_last", ol[k], 1'b0);
      check("rst_busy", bsy[k], 1'b0);
    end

    // Reset mid-UNLOAD on the N=3 instance
    tx[0] = 8'd5; tx[1] = 8'd1; tx[2] = 8'd4;
    send_frame(3, 1'b0, 1'b0);
    guard = 0;
    while (!ov[3] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("mid_valid", ov[3], 1'b1);
    check("mid_word0", od[3], 8'd1);
    ordy[3] = 1'b1;
    @(negedge clk);
    ordy[3] = 1'b0;
    check("mid_word1", od[3], 8'd4);
    rst = 1'b0;
    #1;
    check("arst_out_valid", ov[3], 1'b0);
    check("arst_in_ready", ir[3], 1'b1);
    check("arst_out_data", od[3], 8'h00);
    check("arst_busy", bsy[3], 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tx[0] = 8'd2; tx[1] = 8'd9; tx[2] = 8'd6;
    ex[0] = 8'd2; ex[1] = 8'd6; ex[2] = 8'd9;
    send_frame(3, 1'b0, 1'b0);
    recv_frame(3, 1'b0, 1'b1);

    // Ascending unsigned N=8 with boundary values 0 and 255
    tx = '{8'd7, 8'd3, 8'd255, 8'd0, 8'd3, 8'd9, 8'd1, 8'd128};
    ex = '{8'd0, 8'd1, 8'd3, 8'd3, 8'd7, 8'd9, 8'd128, 8'd255};
    send_frame(0, 1'b0, 1'b0);
    recv_frame(0, 1'b0, 1'b1);

    // Descending signed: -128,5,-1,127,0,5,-7,2
    tx = '{8'h80, 8'h05, 8'hFF, 8'h7F, 8'h00, 8'h05, 8'hF9, 8'h02};
    ex = '{8'h7F, 8'h05, 8'h05, 8'h02, 8'h00, 8'hFF, 8'hF9, 8'h80};
    send_frame(1, 1'b0, 1'b0);
    recv_frame(1, 1'b0, 1'b1);

    // Odd depth worst case
    tx[0] = 8'd4; tx[1] = 8'd3; tx[2] = 8'd2; tx[3] = 8'd1; tx[4] = 8'd0;
    ex[0] = 8'd0; ex[1] = 8'd1; ex[2] = 8'd2; ex[3] = 8'd3; ex[4] = 8'd4;
    send_frame(2, 1'b0, 1'b0);
    recv_frame(2, 1'b0, 1'b1);

    // in_valid held high with 0xAA through SORT and UNLOAD
    tx = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0, 8'd60, 8'd70};
    ex = '{8'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70};
    send_frame(0, 1'b0, 1'b1);
    recv_frame(0, 1'b0, 1'b1);
    tx = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    ex = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_frame(0, 1'b0, 1'b0);
    recv_frame(0, 1'b0, 1'b1);

    // Random back-pressure on both sides over 20 frames
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 8; i++) begin
        tx[i] = 8'($urandom_range(0, (f % 2 == 0) ? 15 : 255));
      end
      ref_sort();
      send_frame(0, 1'b1, 1'b0);
      recv_frame(0, 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
